// File: rtl/regfile_dump.sv
// regfile_dump: streams every register as a byte frame (A5 header, registers little-endian, XOR checksum).
// Ports: clk/rst_n clock and async active-low reset; start requests a dump (IDLE only);
// busy high outside IDLE; done one-cycle pulse per completed frame; rf_ra/rf_rd register
// file read port (combinational read); tx_data/tx_valid/tx_ready byte stream to the transmitter.
module regfile_dump #(
  parameter int NREGS = 32,
  parameter int AW = 5,
  parameter int DW = 32,
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready
);
  typedef enum logic [2:0] {IDLE, HEAD, LOAD, SEND, CSUM} state_t;
  state_t st, nxt;
  logic [AW-1:0] idx;
  logic [1:0] bcnt;
  logic [DW-1:0] shreg;
  logic [7:0] csum;
  logic hs, last;
  assign hs = tx_valid & tx_ready;
  assign last = idx == AW'(NREGS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = start ? HEAD : IDLE;
      HEAD: nxt = hs ? LOAD : HEAD;
      LOAD: nxt = SEND;
      SEND: nxt = (hs && bcnt == 2'd3) ? (last ? CSUM : LOAD) : SEND;
      CSUM: nxt = hs ? IDLE : CSUM;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = st != IDLE;
    tx_valid = st == HEAD || st == SEND || st == CSUM;
    tx_data = st == HEAD ? HDR : st == SEND ? shreg[7:0] : st == CSUM ? csum : 8'h00;
    rf_ra = st == IDLE ? '0 : idx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done <= 1'b0;
      idx <= '0;
      bcnt <= '0;
      shreg <= '0;
      csum <= '0;
    end else begin
      done <= st == CSUM && hs;
      if (st == IDLE && start) begin
        idx <= '0;
        bcnt <= '0;
        csum <= '0;
      end
      if (st == LOAD) shreg <= rf_rd;
      if (st == SEND && hs) begin
        shreg <= shreg >> 8;
        csum <= csum ^ shreg[7:0];
        bcnt <= bcnt + 2'd1;
        if (bcnt == 2'd3 && !last) idx <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: checks regfile_dump frames against a byte-level frame model.
module tb_regfile_dump;
  localparam int NR = 32;
  logic clk = 0, rst_n = 0, start = 0, tx_ready = 1;
  logic busy, done, tx_valid;
  logic [4:0] rf_ra;
  logic [31:0] rf_rd;
  logic [7:0] tx_data;
  logic [31:0] rf [NR];
  logic [31:0] snap [NR];
  logic [7:0] got[$], exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0, done_rel = -1, n_done = 0, n_busy = 0, unstable = 0;
  bit rdy_rnd = 0, pend = 0;
  logic [7:0] pend_data;
  typedef struct { int pat; bit rnd; logic [7:0] csum; } fvec_t;
  typedef struct { int idx; logic [7:0] val; } bvec_t;
  fvec_t fv[4];
  bvec_t bv[10];

  regfile_dump dut (.clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready));

  assign rf_rd = (rf_ra == 0) ? 32'h0 : rf[rf_ra];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always begin
    @(posedge clk);
    #1 tx_ready = rdy_rnd ? 1'($urandom % 2) : 1'b1;
  end

  always @(negedge clk)
    if (!rst_n) pend = 0;
    else begin
      if (pend && !(tx_valid && tx_data == pend_data)) unstable++;
      pend = tx_valid && !tx_ready;
      pend_data = tx_data;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (done) begin
        n_done++;
        done_rel = cyc - t0;
      end
      if (busy) n_busy++;
    end

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic model(input logic [31:0] s [NR]);
    logic [7:0] c;
    logic [31:0] v;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    c = 0;
    for (int r = 0; r < NR; r++) begin
      v = (r == 0) ? 32'h0 : s[r];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(v[8*b +: 8]);
        c ^= v[8*b +: 8];
      end
    end
    exp_q.push_back(c);
  endtask

  task automatic set_rf(input int pat);
    for (int i = 0; i < NR; i++)
      rf[i] = pat == 0 ? 32'h0 : pat == 1 ? (i == 1 ? 32'h12345678 : 32'h0) :
              pat == 2 ? 32'hA0A0A000 + 32'(i) : $urandom;
  endtask

  task automatic start_frame();
    @(posedge clk);
    #1;
    got.delete();
    n_done = 0;
    n_busy = 0;
    done_rel = -1;
    start = 1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    check({nm, "_done_seen"}, 32'(ok), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_send(input int k);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = busy && tx_valid && rf_ra == 5'(k);
    end
    check("reach_send", 32'(ok), 1);
  endtask

  task automatic check_frame(input string nm);
    int bad = 0;
    check({nm, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
    check({nm, "_bytes_bad"}, 32'(bad), 0);
    check({nm, "_ndone"}, 32'(n_done), 1);
  endtask

  initial begin
    fv[0] = '{0, 0, 8'h00};
    fv[1] = '{1, 0, 8'h08};
    fv[2] = '{2, 1, 8'hA0};
    fv[3] = '{2, 0, 8'hA0};
    bv = '{'{0, 8'hA5}, '{1, 8'h00}, '{2, 8'h00}, '{3, 8'h00}, '{4, 8'h00},
           '{5, 8'h78}, '{6, 8'h56}, '{7, 8'h34}, '{8, 8'h12}, '{129, 8'h08}};
    set_rf(0);
    #23;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_ra", 32'(rf_ra), 0);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      set_rf(fv[k].pat);
      model(rf);
      rdy_rnd = fv[k].rnd;
      start_frame();
      check("c1_busy", 32'(busy), 1);
      check("c1_valid", 32'(tx_valid), 1);
      check("c1_hdr", 32'(tx_data), 32'hA5);
      wait_done("tbl");
      check_frame("tbl");
      check("tbl_csum", got.size() == 130 ? 32'(got[129]) : 32'hFFFF, 32'(fv[k].csum));
      if (!fv[k].rnd) begin
        check("tbl_done_cyc", 32'(done_rel), 163);
        check("tbl_busy_cycles", 32'(n_busy), 162);
      end
      if (fv[k].pat == 1)
        foreach (bv[j]) check("byte", j < 10 && bv[j].idx < got.size() ? 32'(got[bv[j].idx]) : 32'hFFFF, 32'(bv[j].val));
    end
    for (int k = 0; k < 3; k++) begin
      set_rf(3);
      model(rf);
      rdy_rnd = 1;
      start_frame();
      wait_done("rnd");
      check_frame("rnd");
    end
    rdy_rnd = 0;
    set_rf(2);
    model(rf);
    start_frame();
    wait_send(10);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("ign");
    repeat (200) @(negedge clk);
    check_frame("ign");
    check("ign_idle", 32'(busy), 0);
    start_frame();
    wait_send(5);
    #2 rst_n = 0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(tx_valid), 0);
    check("mid_rst_data", 32'(tx_data), 0);
    check("mid_rst_ra", 32'(rf_ra), 0);
    @(negedge clk);
    #2 rst_n = 1;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(n_done), 0);
    start_frame();
    wait_done("post_rst");
    check_frame("post_rst");
    snap = rf;
    snap[7] = 32'hDEADBEEF;
    model(snap);
    start_frame();
    wait_send(6);
    rf[7] = 32'hDEADBEEF;
    wait_done("wr_before");
    check_frame("wr_before");
    check("wr_before_r7", got.size() > 32 ? {got[32], got[31], got[30], got[29]} : 32'h0, 32'hDEADBEEF);
    rf[7] = 32'hA0A0A007;
    model(rf);
    start_frame();
    wait_send(7);
    rf[7] = 32'hDEADBEEF;
    wait_done("wr_after");
    check_frame("wr_after");
    check("stable_while_stalled", 32'(unstable), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug reader for the CPU register file. On a start pulse it walks every architectural register through a dedicated read port and streams the contents out as a byte frame over a valid/ready interface. The frame is a sync header, then each register little-endian, then an XOR checksum. It sits between the register file's spare read port and the debug UART transmitter, and never writes the register file.

## Interface
- `NREGS`, 32: number of registers dumped, indices 0..NREGS-1.
- `AW`, 5: register address width; NREGS ≤ 2^AW.
- `DW`, 32: register data width; fixed at 32 (4 bytes per register).
- `HDR`, 8'hA5: sync byte sent first in every frame.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a dump; sampled only in IDLE.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a frame completes.
- `rf_ra`  out  AW  register file read address.
- `rf_rd`  in  DW  register file read data; combinational from `rf_ra`; register 0 reads 0.
- `tx_data`  out  8  byte presented to the transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts the byte this cycle.

## Operation
- States:
  - IDLE: waiting for `start`.
  - HEAD: presenting the header byte.
  - LOAD: capturing one register.
  - SEND: presenting that register's 4 bytes.
  - CSUM: presenting the checksum byte.
- Internal state:
  - `idx` (AW bits): current register index.
  - `bcnt` (2 bits): byte counter within a register.
  - `shreg` (32 bits): captured register value.
  - `csum` (8 bits): running checksum.
- A handshake occurs on a cycle where both `tx_valid` and `tx_ready` are high.
- Transitions:
  - IDLE → HEAD when `start`=1. On that edge, clear `idx`, `bcnt` and `csum`.
  - HEAD → LOAD on handshake.
  - LOAD → SEND unconditionally after one cycle. On that edge, capture `shreg` ← `rf_rd`.
  - SEND: `tx_data` = `shreg[7:0]`. On each handshake, shift `shreg` right 8, XOR the sent byte into `csum`, and increment `bcnt`.
  - SEND, on the handshake of the 4th byte: go to CSUM if `idx` = NREGS-1; otherwise increment `idx` and go to LOAD.
  - CSUM → IDLE on handshake, with `done`=1 in the following cycle.
- Outputs per state:
  - `tx_data` = HDR in HEAD and `csum` in CSUM.
  - `tx_valid` = 1 in HEAD, SEND and CSUM; 0 in IDLE and LOAD.
  - `rf_ra` = `idx` in all states; 0 in IDLE.
- Capture is one register at a time, so the frame is not an atomic snapshot of the whole file. A write to register k is reflected in the frame iff it lands before register k's LOAD edge.
- The checksum is the XOR of the 4·NREGS data bytes only; the header is excluded.
- `start` while `busy`=1 is ignored and is not queued.
- Once `tx_valid` is asserted it holds, and `tx_data` stays stable, until the handshake (AXI-stream rule). `tx_ready` may toggle arbitrarily.
- Frame length is 1 + 4·NREGS + 1 bytes: 130 at the defaults.

## Timing
- Reset (asynchronous, takes effect immediately, also mid-frame):
  - State = IDLE.
  - `busy`, `done`, `tx_valid` = 0.
  - `tx_data`, `rf_ra`, `idx`, `bcnt`, `shreg`, `csum` = 0.
  - A partial frame is abandoned: no checksum, no `done`.
- `start` sampled high in cycle 0 → `busy`=1 and `tx_valid`=1 with `tx_data`=HDR in cycle 1.
- With `tx_ready` held at 1:
  - header in cycle 1;
  - register i's LOAD in cycle 2+5i, its bytes in cycles 3+5i..6+5i;
  - checksum in cycle 5·NREGS+2 (162);
  - `done`=1 and `busy`=0 in cycle 163.
- `start`=1 in the same cycle as `done` begins a new frame: IDLE accepts it.
- LOAD always costs exactly one bubble cycle per register, independent of `tx_ready`.
- `done` is high for exactly one cycle per completed frame.

## Test plan
- **All registers zero, `tx_ready`=1:**
  - start → 130 bytes: A5, 128×00, 00.
  - `done` in cycle 163; `busy` high in cycles 1..162.
- **rf[1]=0x12345678, all others zero:**
  - Bytes 1..8 = 00 00 00 00 78 56 34 12.
  - Checksum = 0x08.
  - Register 0 is always sent as zeros.
- **rf[i]=0xA0A0A000+i for i≥1, random `tx_ready` (~50%):**
  - Byte stream matches the reference model.
  - `tx_data` is stable whenever `tx_valid`=1 and `tx_ready`=0.
  - No byte is dropped or duplicated.
- **`start` pulsed during SEND of register 10:**
  - Ignored: exactly one frame, one `done`.
- **`rst_n` low during SEND of register 5, then start:**
  - Outputs 0 immediately on reset.
  - The new frame begins with A5 and is complete and correct.
- **rf[7] written 0xDEADBEEF before LOAD of register 7 vs. after it:**
  - The new value is sent only in the first case.
